// File: rtl/wd_window_monitor.sv
// rtl/wd_window_monitor.sv - window watchdog: flags early, late or misconfigured heartbeat kicks
// wdfail is a registered level that holds until clr_fail or enable drop; fail_cause/fail_cnt feed status.
module wd_window_monitor #(
  parameter int CNT_W  = 16,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              kick,
  input  logic [CNT_W-1:0]  win_open,
  input  logic [CNT_W-1:0]  timeout,
  input  logic              clr_fail,
  output logic              wdfail,
  output logic              window,
  output logic [1:0]        fail_cause,
  output logic [FCNT_W-1:0] fail_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLOSED = 2'd1,
    S_OPEN   = 2'd2,
    S_FAIL   = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_EARLY   = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_CONFIG  = 2'b11;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W:0]   cnt_inc;
  logic [1:0]       cause_nxt;
  logic             enter_fail;
  logic             kick_d;
  logic             krise;

  assign krise   = kick & ~kick_d;
  assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cause_nxt  = fail_cause;
    enter_fail = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_nxt = '0;
          if (win_open <= timeout) begin
            state_nxt = S_CLOSED;
          end else begin
            state_nxt  = S_FAIL;
            cause_nxt  = CAUSE_CONFIG;
            enter_fail = 1'b1;
          end
        end
        S_CLOSED: begin
          if (krise) begin
            state_nxt  = S_FAIL;
            cause_nxt  = CAUSE_EARLY;
            enter_fail = 1'b1;
          end else begin
            cnt_nxt = cnt_inc[CNT_W-1:0];
            if (cnt_inc >= {1'b0, win_open}) state_nxt = S_OPEN;
          end
        end
        S_OPEN: begin
          // >= rather than ==: after clearing a config error the window can open past timeout.
          if (krise) begin
            state_nxt = S_CLOSED;
            cnt_nxt   = '0;
          end else if (cnt >= timeout) begin
            state_nxt  = S_FAIL;
            cause_nxt  = CAUSE_TIMEOUT;
            enter_fail = 1'b1;
          end else begin
            cnt_nxt = cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          if (clr_fail) begin
            state_nxt = S_CLOSED;
            cnt_nxt   = '0;
            cause_nxt = CAUSE_NONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      kick_d     <= 1'b0;
      wdfail     <= 1'b0;
      window     <= 1'b0;
      fail_cause <= CAUSE_NONE;
      fail_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      kick_d     <= kick;
      wdfail     <= (state_nxt == S_FAIL);
      window     <= (state_nxt == S_OPEN);
      fail_cause <= cause_nxt;
      if (enter_fail && (fail_cnt != {FCNT_W{1'b1}})) fail_cnt <= fail_cnt + 1'b1;
    end
  end

endmodule
